fixed_point_acc_multilane: RTL and testbench
============================================

// Module: fixed_point_acc_multilane
// PURPOSE
//  Second-generation fixed-point accumulator. Sums NUM_INPUTS signed Qm.FRAC_BITS operands
//  (plus an optional bias), taking LANES operands per cycle into a guard-bit-widened register.
//  Saturates the result to WIDTH bits and flags overflow. Valid/ready handshakes on both sides.
//  Sits after the neuron multiplier array, feeding the activation stage.
// PARAMETERS
//  WIDTH         8    operand/result width, two's complement
//  FRAC_BITS     3    fractional bits (>0); all operands share the format, no alignment
//  NUM_INPUTS    16   operands per transaction; must be a multiple of LANES
//  LANES         4    operands summed per accumulate cycle (1..NUM_INPUTS)
//  HAS_EXT_BIAS  1'b0 1: EXT_VALUE_IN added as one extra term after the operands
// PORTS
//  CLK           in   1                 clock, rising edge
//  RSTN          in   1                 asynchronous active-low reset
//  VALUES_IN     in   NUM_INPUTS*WIDTH  operand i at [i*WIDTH +: WIDTH]
//  EXT_VALUE_IN  in   WIDTH             bias; ignored when HAS_EXT_BIAS=0
//  VALID_IN      in   1                 input transaction valid
//  READY_OUT     out  1                 block can accept a transaction
//  VALUE_OUT     out  WIDTH             saturated sum
//  OVERFLOW_OUT  out  1                 1: VALUE_OUT was clamped
//  VALID_OUT     out  1                 result valid
//  READY_IN      in   1                 downstream accepts the result
// BEHAVIOUR
//  - Reset (async, any time): state IDLE; READY_OUT=1, VALID_OUT=0, VALUE_OUT=0, OVERFLOW_OUT=0,
//    accumulator and beat counter 0. A transaction in flight is discarded, with no partial output.
//  - Internal accumulator width: WIDTH+clog2(NUM_INPUTS+2). No intermediate overflow is possible.
//  - States: IDLE -> ACCUMULATE -> [ADD_BIAS] -> DONE -> IDLE.
//  - IDLE: READY_OUT=1. On VALID_IN&READY_OUT at edge T0, register VALUES_IN and EXT_VALUE_IN,
//    clear the accumulator and beat counter, and go to ACCUMULATE. Inputs may change after T0.
//  - ACCUMULATE: READY_OUT=0. On each edge, acc += sign-extended sum of operands
//    [beat*LANES .. beat*LANES+LANES-1], then beat++.
//    After beat NUM_INPUTS/LANES-1, go to ADD_BIAS if HAS_EXT_BIAS, else DONE.
//  - ADD_BIAS: one edge, acc += sign-extended bias, then go to DONE.
//  - Result capture: on the edge entering DONE, register VALUE_OUT and OVERFLOW_OUT.
//    acc > 2^(WIDTH-1)-1 gives 0111..1 with OVERFLOW=1.
//    acc < -2^(WIDTH-1) gives 1000..0 with OVERFLOW=1.
//    Otherwise VALUE_OUT = acc[WIDTH-1:0] and OVERFLOW=0.
//  - Latency, B = NUM_INPUTS/LANES: VALID_OUT rises B edges after T0, or B+1 with bias.
//    Defaults: 4 edges.
//  - DONE: VALID_OUT=1. VALUE_OUT/OVERFLOW_OUT are held stable while READY_IN=0 (no timeout).
//    On an edge with VALID_OUT&READY_IN: VALID_OUT drops and state returns to IDLE.
//  - READY_OUT is high only in IDLE, so there is no accept in DONE.
//    Back-to-back throughput: one result per B+2 (+1 with bias) cycles.
//  - VALID_IN while READY_OUT=0 is ignored; the upstream holds it.
//  - VALUE_OUT/OVERFLOW_OUT keep their last value after the handshake until the next result.
// TESTING (WIDTH=8, FRAC_BITS=3, NUM_INPUTS=16, LANES=4 unless noted)
//  1. All operands 0x04 (0.5), READY_IN=1 -> VALUE_OUT=0x40 (8.0), OVERFLOW=0,
//     VALID_OUT 4 edges after accept, pulse of 1 cycle.
//  2. All 0x08 (1.0) -> 0x7F, OVERFLOW=1. All 0xF0 (-2.0) -> 0x80, OVERFLOW=1.
//  3. Alternating 0x7F/0x81 -> 0x00, OVERFLOW=0; no intermediate wrap.
//  4. HAS_EXT_BIAS=1, operands 0x02, bias 0xF8 (-1.0) -> 0x18 (3.0), latency 5 edges.
//  5. READY_IN=0 for 10 cycles -> VALID_OUT and VALUE_OUT stable and READY_OUT=0;
//     releasing READY_IN gives READY_OUT=1 on the next cycle.
//  6. RSTN low during beat 2 -> all outputs reset immediately, without waiting for a clock edge.
//     A new transaction after release gives the correct sum.
//     Repeat case 1 with LANES=1 and LANES=16.

Source files
------------

// File: rtl/fixed_point_acc_multilane.sv
// Multi-lane signed fixed-point accumulator with saturating output and valid/ready on both sides.
// state      | meaning
// ST_IDLE    | ready for a transaction, last result held
// ST_ACCUM   | summing LANES operands per edge into the guard-widened accumulator
// ST_ADD_BIAS| adding the registered bias as one extra term
// ST_DONE    | result valid, waiting for downstream READY_IN
module fixed_point_acc_multilane #(
  parameter int WIDTH        = 8,
  parameter int FRAC_BITS    = 3,
  parameter int NUM_INPUTS   = 16,
  parameter int LANES        = 4,
  parameter bit HAS_EXT_BIAS = 1'b0
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic [NUM_INPUTS*WIDTH-1:0] VALUES_IN,
  input  logic [WIDTH-1:0]            EXT_VALUE_IN,
  input  logic                        VALID_IN,
  output logic                        READY_OUT,
  output logic [WIDTH-1:0]            VALUE_OUT,
  output logic                        OVERFLOW_OUT,
  output logic                        VALID_OUT,
  input  logic                        READY_IN
);

  localparam int BEATS = NUM_INPUTS / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = WIDTH + $clog2(NUM_INPUTS + 2);
  localparam logic signed [AW-1:0] ACC_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] ACC_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  // All operands share one Q format, so the binary point never needs aligning.
  if (FRAC_BITS < 1 || FRAC_BITS >= WIDTH || (NUM_INPUTS % LANES) != 0) begin : g_bad_cfg
    $error("fixed_point_acc_multilane: invalid parameterisation");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_ADD_BIAS, ST_DONE} state_t;

  state_t                        state_q;
  logic [NUM_INPUTS*WIDTH-1:0]   vals_q;
  logic [WIDTH-1:0]              bias_q;
  logic [BW-1:0]                 beat_q;
  logic signed [AW-1:0]          acc_q;
  logic signed [AW-1:0]          lane_sum;
  logic signed [AW-1:0]          bias_ext;
  logic signed [AW-1:0]          acc_next;
  logic [WIDTH-1:0]              sat_val;
  logic                          sat_ovf;
  logic                          last_beat;

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      logic [WIDTH-1:0] op;
      op = vals_q[(int'(beat_q) * LANES + l) * WIDTH +: WIDTH];
      lane_sum = lane_sum + {{(AW-WIDTH){op[WIDTH-1]}}, op};
    end
  end

  assign bias_ext  = {{(AW-WIDTH){bias_q[WIDTH-1]}}, bias_q};
  assign acc_next  = acc_q + ((state_q == ST_ADD_BIAS) ? bias_ext : lane_sum);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // Saturate the value that is about to be written, so the result lands on the edge entering DONE.
  always_comb begin
    sat_val = acc_next[WIDTH-1:0];
    sat_ovf = 1'b0;
    if (acc_next > ACC_MAX) begin
      sat_val = {1'b0, {(WIDTH-1){1'b1}}};
      sat_ovf = 1'b1;
    end else if (acc_next < ACC_MIN) begin
      sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      sat_ovf = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      vals_q       <= '0;
      bias_q       <= '0;
      beat_q       <= '0;
      acc_q        <= '0;
      READY_OUT    <= 1'b1;
      VALID_OUT    <= 1'b0;
      VALUE_OUT    <= '0;
      OVERFLOW_OUT <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (VALID_IN && READY_OUT) begin
            vals_q    <= VALUES_IN;
            bias_q    <= EXT_VALUE_IN;
            acc_q     <= '0;
            beat_q    <= '0;
            READY_OUT <= 1'b0;
            state_q   <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          acc_q  <= acc_next;
          beat_q <= beat_q + BW'(1);
          if (last_beat) begin
            beat_q <= '0;
            if (HAS_EXT_BIAS) begin
              state_q <= ST_ADD_BIAS;
            end else begin
              VALUE_OUT    <= sat_val;
              OVERFLOW_OUT <= sat_ovf;
              VALID_OUT    <= 1'b1;
              state_q      <= ST_DONE;
            end
          end
        end
        ST_ADD_BIAS: begin
          acc_q        <= acc_next;
          VALUE_OUT    <= sat_val;
          OVERFLOW_OUT <= sat_ovf;
          VALID_OUT    <= 1'b1;
          state_q      <= ST_DONE;
        end
        ST_DONE: begin
          if (READY_IN) begin
            VALID_OUT <= 1'b0;
            READY_OUT <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_acc_multilane.sv
// Runs four configurations side by side (default, bias, LANES=1, LANES=16) against an integer-sum model.
module tb_fixed_point_acc_multilane;
  localparam int W = 8;
  localparam int N = 16;

  logic             CLK = 1'b0;
  logic             RSTN = 1'b0;
  logic [N*W-1:0]   vin = '0;
  logic [W-1:0]     bias = '0;
  logic             vld = 1'b0;
  logic             rdy_in = 1'b1;
  logic [3:0]       ro, vo_v, ov;
  logic [3:0][W-1:0] vo;

  int compared = 0;
  int mismatched = 0;
  int exp_lat[4] = '{4, 5, 16, 1};

  always #5 CLK = ~CLK;

  fixed_point_acc_multilane #(.LANES(4)) u_d0 (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(vin), .EXT_VALUE_IN(bias), .VALID_IN(vld),
    .READY_OUT(ro[0]), .VALUE_OUT(vo[0]), .OVERFLOW_OUT(ov[0]), .VALID_OUT(vo_v[0]), .READY_IN(rdy_in));
  fixed_point_acc_multilane #(.LANES(4), .HAS_EXT_BIAS(1'b1)) u_d1 (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(vin), .EXT_VALUE_IN(bias), .VALID_IN(vld),
    .READY_OUT(ro[1]), .VALUE_OUT(vo[1]), .OVERFLOW_OUT(ov[1]), .VALID_OUT(vo_v[1]), .READY_IN(rdy_in));
  fixed_point_acc_multilane #(.LANES(1)) u_d2 (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(vin), .EXT_VALUE_IN(bias), .VALID_IN(vld),
    .READY_OUT(ro[2]), .VALUE_OUT(vo[2]), .OVERFLOW_OUT(ov[2]), .VALID_OUT(vo_v[2]), .READY_IN(rdy_in));
  fixed_point_acc_multilane #(.LANES(16)) u_d3 (
    .CLK(CLK), .RSTN(RSTN), .VALUES_IN(vin), .EXT_VALUE_IN(bias), .VALID_IN(vld),
    .READY_OUT(ro[3]), .VALUE_OUT(vo[3]), .OVERFLOW_OUT(ov[3]), .VALID_OUT(vo_v[3]), .READY_IN(rdy_in));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain integer sum of the signed operands (plus bias), then clamped to the result width.
  task automatic model(input logic [N*W-1:0] v, input logic [W-1:0] b, input bit use_b,
                       output logic [W-1:0] e_val, output logic e_ovf);
    int s = 0;
    for (int i = 0; i < N; i++) s += int'($signed(v[i*W +: W]));
    if (use_b) s += int'($signed(b));
    e_ovf = 1'b1;
    if (s > 127) e_val = 8'h7F;
    else if (s < -128) e_val = 8'h80;
    else begin
      e_val = W'(s);
      e_ovf = 1'b0;
    end
  endtask

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  function automatic logic [N*W-1:0] fill(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  task automatic send(input logic [N*W-1:0] v, input logic [W-1:0] b, input string tag);
    int guard = 0;
    while (ro !== 4'hF && guard < 50) begin
      @(posedge CLK); #1;
      guard++;
    end
    check({tag, " ready_before"}, 32'(ro), 32'hF);
    @(negedge CLK);
    vin = v; bias = b; vld = 1'b1;
    @(posedge CLK); #1;
    vld = 1'b0;
    vin = rand_vec();
    bias = W'($urandom);
  endtask

  task automatic run_txn(input logic [N*W-1:0] v, input logic [W-1:0] b, input string tag);
    int lat[4] = '{-1, -1, -1, -1};
    logic [W-1:0] e_val;
    logic e_ovf;
    send(v, b, tag);
    for (int e = 1; e <= 20; e++) begin
      @(posedge CLK); #1;
      for (int d = 0; d < 4; d++) begin
        if (vo_v[d] === 1'b1 && lat[d] < 0) begin
          lat[d] = e;
          model(v, b, d == 1, e_val, e_ovf);
          check($sformatf("%s d%0d value", tag, d), 32'(vo[d]), 32'(e_val));
          check($sformatf("%s d%0d ovf", tag, d), 32'(ov[d]), 32'(e_ovf));
        end else if (lat[d] >= 0 && lat[d] == e - 1) begin
          check($sformatf("%s d%0d pulse", tag, d), 32'(vo_v[d]), 32'h0);
        end
      end
    end
    for (int d = 0; d < 4; d++)
      check($sformatf("%s d%0d latency", tag, d), 32'(lat[d]), 32'(exp_lat[d]));
  endtask

  initial begin
    logic [W-1:0] e_val;
    logic e_ovf;
    logic [3:0][W-1:0] snap;

    repeat (2) @(negedge CLK);
    check("rst ready", 32'(ro), 32'hF);
    check("rst valid", 32'(vo_v), 32'h0);
    check("rst value", 32'(vo), 32'h0);
    check("rst ovf", 32'(ov), 32'h0);
    RSTN = 1'b1;
    @(negedge CLK);

    run_txn(fill(8'h04, 8'h04), 8'hF8, "half");
    run_txn(fill(8'h08, 8'h08), 8'h00, "sat_pos");
    run_txn(fill(8'hF0, 8'hF0), 8'h00, "sat_neg");
    run_txn(fill(8'h7F, 8'h81), 8'h40, "alt");
    run_txn(fill(8'h02, 8'h02), 8'hF8, "bias");
    for (int t = 0; t < 20; t++) begin
      logic [N*W-1:0] rv;
      rv = rand_vec();
      if (t % 4 == 0)
        for (int i = 0; i < N; i++) rv[i*W +: W] = W'($urandom_range(0, 15)) - 8'd6;
      run_txn(rv, W'($urandom), $sformatf("rand%0d", t));
    end

    // Downstream stalls: result must hold and no new accept may happen.
    rdy_in = 1'b0;
    send(fill(8'h04, 8'h04), 8'h08, "stall");
    repeat (20) @(posedge CLK);
    #1;
    check("stall valid", 32'(vo_v), 32'hF);
    snap = vo;
    for (int d = 0; d < 4; d++) begin
      model(fill(8'h04, 8'h04), 8'h08, d == 1, e_val, e_ovf);
      check($sformatf("stall d%0d value", d), 32'(vo[d]), 32'(e_val));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge CLK); #1;
      check("stall hold valid", 32'(vo_v), 32'hF);
      check("stall hold value", 32'(vo), 32'(snap));
      check("stall hold ready", 32'(ro), 32'h0);
    end
    @(negedge CLK);
    rdy_in = 1'b1;
    @(posedge CLK); #1;
    check("release valid", 32'(vo_v), 32'h0);
    check("release ready", 32'(ro), 32'hF);
    check("release keeps value", 32'(vo), 32'(snap));

    // Asynchronous reset in the middle of beat 2.
    send(fill(8'h03, 8'h05), 8'h10, "midrst");
    @(posedge CLK);
    @(posedge CLK);
    #3;
    RSTN = 1'b0;
    #1;
    check("async ready", 32'(ro), 32'hF);
    check("async valid", 32'(vo_v), 32'h0);
    check("async value", 32'(vo), 32'h0);
    check("async ovf", 32'(ov), 32'h0);
    @(negedge CLK);
    RSTN = 1'b1;
    run_txn(rand_vec(), W'($urandom), "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
